back_ground_scroll_draw: RTL

// - Parametrised successor to the static two-bank/river background painter. Splits the river into
//   N_LANES horizontal lanes and animates each lane with scrolling wave highlights.
// - Sits between the VGA controller coordinates and the object-priority mux.
// - Output is registered: 1-cycle latency.
// - Also exports lane/river info per pixel for the frog-collision logic.

---
 rtl/back_ground_scroll_draw_pkg.sv | 16 +
 rtl/back_ground_scroll_draw_if.sv | 28 ++
 rtl/back_ground_scroll_draw_lane_phase_counter.sv | 22 ++
 rtl/back_ground_scroll_draw.sv | 111 +++++++++++
 4 files changed

// File: rtl/back_ground_scroll_draw_pkg.sv
// rtl/back_ground_scroll_draw_pkg.sv - shared colour type, palette and lane geometry helper
package back_ground_pkg;

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t BLANK   = 8'h00;
    localparam rgb332_t BANK    = 8'b010_001_00;
    localparam rgb332_t WATER   = 8'b000_000_11;
    localparam rgb332_t WAVE_HI = 8'b011_011_11;

    // Height of one river lane; the river spans the screen minus both banks
    function automatic int lane_height(input int screen_h, input int bank_w, input int n_lanes);
        return (screen_h - 2 * bank_w) / n_lanes;
    endfunction

endpackage

// File: rtl/back_ground_scroll_draw_if.sv
// rtl/back_ground_scroll_draw_if.sv - pixel coordinate in, background colour and lane info out
interface back_ground_scroll_draw_if #(
    parameter int LANE_W = 2
);
    import back_ground_pkg::*;

    logic [10:0]       oCoord_X;
    logic [10:0]       oCoord_Y;
    logic              anim_en;
    rgb332_t           mVGA_RGB;
    logic [8:0]        bank_width;
    logic              in_river;
    logic [LANE_W-1:0] lane_id;
    logic              frame_tick;

    // VGA-controller side: drives coordinates, consumes the background pixel
    modport master (
        output oCoord_X, oCoord_Y, anim_en,
        input  mVGA_RGB, bank_width, in_river, lane_id, frame_tick
    );

    // Painter side
    modport slave (
        input  oCoord_X, oCoord_Y, anim_en,
        output mVGA_RGB, bank_width, in_river, lane_id, frame_tick
    );

endinterface

// File: rtl/back_ground_scroll_draw_lane_phase_counter.sv
// rtl/back_ground_scroll_draw_lane_phase_counter.sv - per-lane wave phase, wraps modulo STRIPE_LEN
module lane_phase_counter #(
    parameter int STRIPE_LEN = 32,
    parameter int DIR        = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          step,
    output logic [$clog2(STRIPE_LEN)-1:0] phase
);
    localparam int PW = $clog2(STRIPE_LEN);

    // Power-of-two stripe length lets the natural register overflow do the wrap
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase <= '0;
        end else if (step) begin
            phase <= (DIR > 0) ? phase + PW'(1) : phase - PW'(1);
        end
    end

endmodule

// File: rtl/back_ground_scroll_draw.sv
// rtl/back_ground_scroll_draw.sv - banked river background with per-lane scrolling wave highlights
module back_ground_scroll_draw
    import back_ground_pkg::*;
#(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int BANK_W          = 80,
    parameter int N_LANES         = 4,
    parameter int STRIPE_LEN      = 32,
    parameter int HILITE_W        = 4,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    back_ground_scroll_draw_if.slave  bus
);
    localparam int LANE_H = lane_height(SCREEN_H, BANK_W, N_LANES);
    localparam int PW     = $clog2(STRIPE_LEN);
    localparam int LW     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int CW     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic          at_origin;
    logic          at_origin_q;
    logic          sof;
    logic          sof_q;
    logic [CW-1:0] frame_cnt;
    logic          step;
    logic [PW-1:0] phase [N_LANES];

    rgb332_t       colour_d;
    logic          river_d;
    logic [LW-1:0] lane_d;
    logic [10:0]   wave_sum;

    // Edge-detect the origin so a stalled (0,0) still yields one start-of-frame
    assign at_origin = (bus.oCoord_X == 11'd0) && (bus.oCoord_Y == 11'd0);
    assign sof       = at_origin && !at_origin_q;
    assign step      = sof && bus.anim_en && (frame_cnt == CW'(FRAMES_PER_STEP - 1));

    assign bus.frame_tick = sof_q;
    assign bus.bank_width = 9'(BANK_W);

    // Origin history and the registered start-of-frame pulse
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            at_origin_q <= 1'b0;
            sof_q       <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
            sof_q       <= sof;
        end
    end

    // Frames-per-step divider; frozen together with the phases while animation is off
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_cnt <= '0;
        end else if (sof && bus.anim_en) begin
            frame_cnt <= step ? '0 : frame_cnt + CW'(1);
        end
    end

    // Even lanes drift left, odd lanes drift right
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        lane_phase_counter #(
            .STRIPE_LEN (STRIPE_LEN),
            .DIR        ((i % 2 == 0) ? 1 : -1)
        ) u_phase (
            .CLK   (CLK),
            .RESET (RESET),
            .step  (step),
            .phase (phase[i])
        );
    end

    // Region and lane decode from the live coordinates; lanes found by constant compares
    always_comb begin
        colour_d = BLANK;
        river_d  = 1'b0;
        lane_d   = '0;
        wave_sum = '0;
        if (bus.oCoord_X >= 11'(SCREEN_W) || bus.oCoord_Y >= 11'(SCREEN_H)) begin
            colour_d = BLANK;
        end else if (bus.oCoord_Y < 11'(BANK_W) || bus.oCoord_Y >= 11'(SCREEN_H - BANK_W)) begin
            colour_d = BANK;
        end else begin
            river_d = 1'b1;
            for (int i = 1; i < N_LANES; i++) begin
                if (bus.oCoord_Y >= 11'(BANK_W + i * LANE_H)) begin
                    lane_d = LW'(i);
                end
            end
            wave_sum = bus.oCoord_X + 11'(phase[lane_d]);
            colour_d = (wave_sum[PW-1:0] < PW'(HILITE_W)) ? WAVE_HI : WATER;
        end
    end

    // One-clock output register, matched by the sync delay in the VGA controller
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.mVGA_RGB <= BLANK;
            bus.in_river <= 1'b0;
            bus.lane_id  <= '0;
        end else begin
            bus.mVGA_RGB <= colour_d;
            bus.in_river <= river_d;
            bus.lane_id  <= lane_d;
        end
    end

endmodule
